// File: rtl/layer_result_writer_pkg.sv
// Shared constants and FSM encoding for the layer result writer.
package layer_result_writer_pkg;

  localparam int unsigned LRW_NUM_BANK      = 16;
  localparam int unsigned LRW_DATA_W        = 128;
  localparam int unsigned LRW_PIX_W         = 32;
  localparam int unsigned LRW_ADDR_W        = 9;
  localparam int unsigned LRW_WORDS_PER_ROW = 64;
  localparam int unsigned LRW_NUM_ROWS      = 128;
  localparam int unsigned LRW_LANES         = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/layer_result_writer_result_packer.sv
// Lane counter plus pack register: collects LANES pixels into one zero-padded word.
module layer_result_writer_result_packer
  import layer_result_writer_pkg::*;
#(
  parameter int unsigned PIX_W = LRW_PIX_W,
  parameter int unsigned LANES = LRW_LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_vld,
  input  logic                   i_last,
  input  logic [PIX_W-1:0]       i_pix,
  output logic                   o_word_done,
  output logic [LANES*PIX_W-1:0] o_word
);

  localparam int unsigned LaneW = $clog2(LANES);

  logic [LaneW-1:0]       r_lane;
  logic [LANES*PIX_W-1:0] r_pack;
  logic                   w_lane_full;

  assign w_lane_full = (r_lane == LaneW'(LANES - 1));
  assign o_word_done = i_vld & (w_lane_full | i_last);

  // Current pack register with the incoming pixel merged into its slot.
  always_comb begin
    o_word = r_pack;
    if (i_vld) begin
      o_word[r_lane*PIX_W +: PIX_W] = i_pix;
    end
  end

  // Slot state: cleared after each completed word so unfilled slots read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane <= '0;
      r_pack <= '0;
    end else if (i_clear || o_word_done) begin
      r_lane <= '0;
      r_pack <= '0;
    end else if (i_vld) begin
      r_lane <= r_lane + 1'b1;
      r_pack <= o_word;
    end
  end

endmodule

// File: rtl/layer_result_writer.sv
// Packs a 32-bit pixel stream into 128-bit words and writes them row-interleaved
// across the feature-map BRAM banks (row r -> bank r mod NUM_BANK).
module layer_result_writer
  import layer_result_writer_pkg::*;
#(
  parameter int unsigned NUM_BANK      = LRW_NUM_BANK,
  parameter int unsigned DATA_W        = LRW_DATA_W,
  parameter int unsigned PIX_W         = LRW_PIX_W,
  parameter int unsigned ADDR_W        = LRW_ADDR_W,
  parameter int unsigned WORDS_PER_ROW = LRW_WORDS_PER_ROW,
  parameter int unsigned NUM_ROWS      = LRW_NUM_ROWS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic [PIX_W-1:0]    iLayer_result,
  input  logic                iLayer_vld,
  input  logic                iColEnd,
  output logic                oWe,
  output logic [NUM_BANK-1:0] oCs,
  output logic [ADDR_W-1:0]   oAddr,
  output logic [DATA_W-1:0]   oWdata,
  output logic                oBusy,
  output logic                oDone,
  output logic                oErr
);

  localparam int unsigned BankW = $clog2(NUM_BANK);
  localparam int unsigned WordW = $clog2(WORDS_PER_ROW);
  // Row counter is wide enough that its upper bits cover the full address space.
  localparam int unsigned RowW  = ADDR_W + BankW;

  state_e              r_state;
  state_e              w_state_next;
  logic [WordW-1:0]    r_word;
  logic [RowW-1:0]     r_row;
  logic                r_we;
  logic [NUM_BANK-1:0] r_cs;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_err;

  logic                w_run;
  logic                w_pix_vld;
  logic                w_stray_vld;
  logic                w_word_done;
  logic [DATA_W-1:0]   w_word;
  logic                w_word_last;
  logic                w_frame_end;
  logic                w_wrap;
  logic [ADDR_W-1:0]   w_addr;
  logic [NUM_BANK-1:0] w_cs;

  // iStart wins over a coincident pixel, which is dropped.
  assign w_run       = (r_state == StRun);
  assign w_pix_vld   = iLayer_vld & w_run & ~iStart;
  assign w_stray_vld = iLayer_vld & ~w_run & ~iStart;
  assign w_word_last = (r_word == WordW'(WORDS_PER_ROW - 1));
  assign w_frame_end = w_pix_vld & iColEnd & (r_row == RowW'(NUM_ROWS - 1));
  // A full last-slot word without iColEnd means the row overruns the bank row.
  assign w_wrap      = w_word_done & ~iColEnd & w_word_last;

  assign w_addr = ADDR_W'(r_row[RowW-1:BankW] * WORDS_PER_ROW) + ADDR_W'(r_word);
  assign w_cs   = NUM_BANK'(1) << r_row[BankW-1:0];

  layer_result_writer_result_packer #(
    .PIX_W (PIX_W),
    .LANES (DATA_W / PIX_W)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (iStart),
    .i_vld       (w_pix_vld),
    .i_last      (iColEnd),
    .i_pix       (iLayer_result),
    .o_word_done (w_word_done),
    .o_word      (w_word)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; iStart restarts the frame from any state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (iStart) w_state_next = StRun;
      end
      StRun: begin
        if (!iStart && w_frame_end) w_state_next = StDone;
      end
      StDone: begin
        w_state_next = iStart ? StRun : StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM status outputs.
  always_comb begin
    oBusy = (r_state == StRun);
    oDone = (r_state == StDone);
  end

  // Word and row position within the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_row  <= '0;
    end else if (iStart) begin
      r_word <= '0;
      r_row  <= '0;
    end else if (w_word_done) begin
      if (iColEnd) begin
        r_word <= '0;
        r_row  <= r_row + 1'b1;
      end else begin
        r_word <= w_word_last ? '0 : r_word + 1'b1;
      end
    end
  end

  // Registered BRAM write port; address and data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_cs    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_word_done;
      r_cs <= w_word_done ? w_cs : '0;
      if (w_word_done) begin
        r_addr  <= w_addr;
        r_wdata <= w_word;
      end
    end
  end

  // Sticky error: stray pixels outside RUN or row overrun; cleared by iStart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (iStart) begin
      r_err <= 1'b0;
    end else if (w_stray_vld || w_wrap) begin
      r_err <= 1'b1;
    end
  end

  assign oWe    = r_we;
  assign oCs    = r_cs;
  assign oAddr  = r_addr;
  assign oWdata = r_wdata;
  assign oErr   = r_err;

endmodule

// File: tb/tb_layer_result_writer.sv
// Scoreboard bench: a pixel-position model predicts each BRAM write; a monitor compares.
module tb_layer_result_writer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iStart = 1'b0;
  logic [31:0]  iLayer_result = '0;
  logic         iLayer_vld = 1'b0;
  logic         iColEnd = 1'b0;
  logic         oWe;
  logic [15:0]  oCs;
  logic [8:0]   oAddr;
  logic [127:0] oWdata;
  logic         oBusy;
  logic         oDone;
  logic         oErr;

  layer_result_writer dut (
    .clk           (clk),
    .rst           (rst),
    .iStart        (iStart),
    .iLayer_result (iLayer_result),
    .iLayer_vld    (iLayer_vld),
    .iColEnd       (iColEnd),
    .oWe           (oWe),
    .oCs           (oCs),
    .oAddr         (oAddr),
    .oWdata        (oWdata),
    .oBusy         (oBusy),
    .oDone         (oDone),
    .oErr          (oErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  cs;
    logic [8:0]   addr;
    logic [127:0] data;
    bit           last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  // Reference model state: frame position in pixels, not in RTL counters.
  bit          m_run = 0;
  int          m_row = 0;
  int          m_pos = 0;
  logic [31:0] m_buf[$];
  bit          m_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_cycle(input bit start, input bit vld, input logic [31:0] pix,
                             input bit ce);
    exp_t e;
    if (start) begin
      m_run = 1;
      m_row = 0;
      m_pos = 0;
      m_buf.delete();
      m_err = 0;
    end else if (vld) begin
      if (!m_run) begin
        m_err = 1;
      end else begin
        m_buf.push_back(pix);
        if (m_pos % 4 == 3 || ce) begin
          e.data = '0;
          foreach (m_buf[k]) e.data[32*k +: 32] = m_buf[k];
          e.addr = 9'(((m_row / 16) * 64 + (m_pos / 4) % 64) % 512);
          e.cs   = 16'(1) << (m_row % 16);
          e.last = ce && (m_row == 127);
          exp_q.push_back(e);
          m_buf.delete();
          if (!ce && (m_pos + 1) % 256 == 0) m_err = 1;
        end
        m_pos++;
        if (ce) begin
          m_pos = 0;
          m_row++;
          if (m_row == 128) m_run = 0;
        end
      end
    end
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input bit start, input bit vld, input logic [31:0] pix, input bit ce);
    iStart        = start;
    iLayer_vld    = vld;
    iLayer_result = pix;
    iColEnd       = ce;
    model_cycle(start, vld, pix, ce);
    @(posedge clk);
    #1;
    iStart     = 1'b0;
    iLayer_vld = 1'b0;
    iColEnd    = 1'b0;
  endtask

  // Row of n pixels with random idle gaps (and stray iColEnd during gaps).
  task automatic send_row(input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < gap_pct) cyc(0, 0, $urandom, 1'($urandom_range(1)));
      cyc(0, 1, $urandom, (i == n - 1));
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (oWe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got cs=%h addr=%h data=%h, expected no write",
                   oCs, oAddr, oWdata);
        end else begin
          e = exp_q.pop_front();
          check("write_cs", oCs, e.cs);
          check("write_addr", oAddr, e.addr);
          check("write_data", oWdata, e.data);
          check("done_at_last_write", oDone, e.last);
        end
      end else begin
        check("cs_without_we", oCs, 0);
        check("done_without_write", oDone, 0);
      end
      if (oDone) done_seen++;
    end
  end

  logic [31:0] p5, p6;

  initial begin
    // Reset state
    #12;
    check("rst_we", oWe, 0);
    check("rst_cs", oCs, 0);
    check("rst_addr", oAddr, 0);
    check("rst_wdata", oWdata, 0);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_err", oErr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Stray pixel in IDLE
    cyc(0, 1, 32'hdeadbeef, 0);
    check("idle_vld_err", oErr, 1);
    check("idle_busy", oBusy, 0);

    // Start clears error
    cyc(1, 0, 0, 0);
    check("start_err_clear", oErr, 0);
    check("start_busy", oBusy, 1);

    // Row 0: four known pixels
    cyc(0, 1, 32'h1, 0);
    cyc(0, 1, 32'h2, 0);
    cyc(0, 1, 32'h3, 0);
    cyc(0, 1, 32'h4, 1);
    check("t2_we", oWe, 1);
    check("t2_cs", oCs, 16'h0001);
    check("t2_addr", oAddr, 0);
    check("t2_wdata", oWdata, 128'h00000004_00000003_00000002_00000001);

    // Row 1: six pixels, second word half-filled
    for (int i = 0; i < 4; i++) cyc(0, 1, $urandom, 0);
    p5 = $urandom;
    p6 = $urandom;
    cyc(0, 1, p5, 0);
    cyc(0, 1, p6, 1);
    check("t4_addr", oAddr, 1);
    check("t4_cs", oCs, 16'h0002);
    check("t4_wdata", oWdata, {64'h0, p6, p5});

    // Partial row dropped by iStart (coincident pixel also dropped)
    cyc(0, 1, $urandom, 0);
    cyc(0, 1, $urandom, 0);
    cyc(1, 1, $urandom, 0);
    check("t5_no_we", oWe, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, $urandom, 0);
    cyc(0, 1, $urandom, 1);
    check("t5_cs", oCs, 16'h0001);
    check("t5_addr", oAddr, 0);

    // 17 rows of 8 pixels, continuous
    for (int r = 0; r < 17; r++) send_row(8, 0);

    // Random rows to the end of the frame, one overlong row included
    while (m_run) begin
      if (m_row == 40) send_row(260, 10);
      else send_row($urandom_range(24, 1), 30);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("frame_busy_low", oBusy, 0);
    check("frame_err_overrun", oErr, m_err);
    check("frame_done_count", done_seen, 1);

    // Stray pixel after DONE, then restart clears
    cyc(0, 1, $urandom, 1);
    check("after_done_err", oErr, 1);
    cyc(1, 0, 0, 0);
    check("restart_err_clear", oErr, 0);

    // Async reset squashes a write in flight
    for (int i = 0; i < 3; i++) cyc(0, 1, $urandom, 0);
    iLayer_vld    = 1'b1;
    iLayer_result = $urandom;
    @(posedge clk);
    #1;
    iLayer_vld = 1'b0;
    check("pre_rst_we", oWe, 1);
    rst = 1'b1;
    #1;
    check("async_rst_we", oWe, 0);
    check("async_rst_cs", oCs, 0);
    check("async_rst_busy", oBusy, 0);
    m_run = 0;
    m_buf.delete();
    m_err = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
